// File: rtl/reg_file_mp_pkg.sv
// Shared constants, types and FSM states for the multi-port register file.
// Pure type definitions: there is no logic here, so there is no latency and no backpressure.
package rf_pkg;
    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;
endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
// The dbg_ra/dbg_rd pair exists only when RF_DEBUG_PORT_EN is defined.
interface reg_file_mp_if #(
    parameter int DW     = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 3
);
    localparam int AW = $clog2(DEPTH);

    logic                   clr_req;
    logic                   ready;
    logic [NUM_RD*AW-1:0]   ra;
    logic [NUM_RD*DW-1:0]   rd;
    logic                   we0;
    logic                   we1;
    logic [AW-1:0]          wa0;
    logic [AW-1:0]          wa1;
    logic [DW-1:0]          wd0;
    logic [DW-1:0]          wd1;
    logic                   pend_set;
    logic [AW-1:0]          pend_sa;
    logic [DEPTH-1:0]       pend;
`ifdef RF_DEBUG_PORT_EN
    logic [AW-1:0]          dbg_ra;
    logic [DW-1:0]          dbg_rd;
`endif

    modport master (
        output clr_req, ra, we0, we1, wa0, wa1, wd0, wd1, pend_set, pend_sa,
`ifdef RF_DEBUG_PORT_EN
        output dbg_ra,
        input  dbg_rd,
`endif
        input  ready, rd, pend
    );

    modport slave (
        input  clr_req, ra, we0, we1, wa0, wa1, wd0, wd1, pend_set, pend_sa,
`ifdef RF_DEBUG_PORT_EN
        input  dbg_ra,
        output dbg_rd,
`endif
        output ready, rd, pend
    );
endinterface

// File: rtl/reg_file_mp_bypass.sv
// One read port: register 0 reads as zero, then WB1 then WB0 bypass, else array data.
// Purely combinational, so it adds zero latency and has no backpressure.
module rf_bypass_mux #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] ra,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic [DW-1:0] rf_dat,
    output logic [DW-1:0] rd
);
    always_comb begin
        rd = '0;
        if (ra == '0)
            rd = '0;
        else if (we1 && (wa1 == ra))
            rd = wd1;
        else if (we0 && (wa0 == ra))
            rd = wd0;
        else
            rd = rf_dat;
    end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: bypassed reads, 2 write ports, pending scoreboard, clear sweep.
// Reads have 0 latency, writes commit at the next edge, no backpressure; RF_DEBUG_PORT_EN adds dbg_ra/dbg_rd.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DW     = RF_DW,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = 3
) (
    input  logic          clk,
    input  logic          rstn,
    reg_file_mp_if.slave  bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FIRST = AW'(1);

    rf_state_t        state_q, state_n;
    logic [AW-1:0]    cnt_q, cnt_n;
    logic [DEPTH-1:0] pend_q, pend_n;
    logic [DW-1:0]    rf [DEPTH];
    logic             idle;
    logic             wr0, wr1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RF_CLEAR;
            cnt_q   <= FIRST;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Register 0 is never swept or written; every read path masks it.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            RF_IDLE: begin
                if (bus.clr_req) begin
                    state_n = RF_CLEAR;
                    cnt_n   = FIRST;
                end
            end
            RF_CLEAR: begin
                if (bus.clr_req)
                    cnt_n = FIRST;
                else if (cnt_q == LAST)
                    state_n = RF_IDLE;
                else
                    cnt_n = cnt_q + FIRST;
            end
            default: begin
                state_n = RF_CLEAR;
                cnt_n   = FIRST;
            end
        endcase
    end

    assign idle      = (state_q == RF_IDLE);
    assign bus.ready = idle;
    assign wr0       = idle && bus.we0 && (bus.wa0 != '0);
    assign wr1       = idle && bus.we1 && (bus.wa1 != '0);

    // WB1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!idle) begin
            rf[cnt_q] <= '0;
        end else begin
            if (wr0) rf[bus.wa0] <= bus.wd0;
            if (wr1) rf[bus.wa1] <= bus.wd1;
        end
    end

    always_comb begin
        pend_n = pend_q;
        if (idle) begin
            if (bus.clr_req) begin
                pend_n = '0;
            end else begin
                if (wr0) pend_n[bus.wa0] = 1'b0;
                if (wr1) pend_n[bus.wa1] = 1'b0;
                if (bus.pend_set && (bus.pend_sa != '0)) pend_n[bus.pend_sa] = 1'b1;
            end
        end
        pend_n[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pend_q <= '0;
        else       pend_q <= pend_n;
    end

    assign bus.pend = pend_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra_k;
        logic [DW-1:0] rd_k;

        assign ra_k = bus.ra[k*AW +: AW];

        rf_bypass_mux #(.DW(DW), .AW(AW)) u_mux (
            .ra     (ra_k),
            .we0    (wr0),
            .wa0    (bus.wa0),
            .wd0    (bus.wd0),
            .we1    (wr1),
            .wa1    (bus.wa1),
            .wd1    (bus.wd1),
            .rf_dat (rf[ra_k]),
            .rd     (rd_k)
        );

        assign bus.rd[k*DW +: DW] = idle ? rd_k : '0;
    end

`ifdef RF_DEBUG_PORT_EN
    logic [DW-1:0] dbg_q;

    // Raw array view, deliberately live during the sweep and free of bypass.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                   dbg_q <= '0;
        else if (bus.dbg_ra == '0)   dbg_q <= '0;
        else                         dbg_q <= rf[bus.dbg_ra];
    end

    assign bus.dbg_rd = dbg_q;
`endif
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp: sweep timing, bypass, collisions, scoreboard and clear restart.
// Inputs change 1 time unit after the rising edge, and outputs are sampled before the next rising edge.
module tb_reg_file_mp;
    localparam int DW     = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 3;
    localparam int AW     = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();

    reg_file_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a);
        bus.ra = {NUM_RD{a}};
    endtask

    task automatic quiet();
        bus.clr_req  = 1'b0;
        bus.we0      = 1'b0;
        bus.we1      = 1'b0;
        bus.wa0      = '0;
        bus.wa1      = '0;
        bus.wd0      = '0;
        bus.wd1      = '0;
        bus.pend_set = 1'b0;
        bus.pend_sa  = '0;
    endtask

    function automatic logic [DW-1:0] rdp(input int k);
        return bus.rd[k*DW +: DW];
    endfunction

    initial begin
        quiet();
        set_ra('0);
`ifdef RF_DEBUG_PORT_EN
        bus.dbg_ra = '0;
`endif
        #12;
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_pend", 64'(bus.pend), 64'd0);

        @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 100 && !bus.ready; i++) tick();
        chk("init_ready", 64'(bus.ready), 64'd1);

        // Preload r5 and a pending bit so the later reset has something to wipe.
        bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'h1234;
        bus.pend_set = 1'b1; bus.pend_sa = 5'd6;
        tick();
        quiet();
        set_ra(5'd5);
        #1;
        chk("pre_r5", 64'(rdp(0)), 64'h1234);
        chk("pre_pend", 64'(bus.pend), 64'h40);

        rstn = 1'b0;
        #1;
        chk("arst_ready", 64'(bus.ready), 64'd0);
        chk("arst_pend", 64'(bus.pend), 64'd0);
        tick();
        rstn = 1'b1;
        bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hDEAD_BEEF;
        #1;
        for (int i = 0; i < 31; i++) begin
            chk("sweep_ready", 64'(bus.ready), 64'd0);
            chk("sweep_rd", 64'(|bus.rd), 64'd0);
            tick();
        end
        quiet();
        #1;
        chk("sweep_done", 64'(bus.ready), 64'd1);
        chk("r5_cleared", 64'(rdp(0)), 64'd0);

        bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h11;
        bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h22;
        set_ra(5'd7);
        #1;
        chk("coll_bypass", 64'(rdp(0)), 64'h22);
        tick();
        quiet();
        #1;
        chk("coll_commit", 64'(rdp(1)), 64'h22);
`ifdef RF_DEBUG_PORT_EN
        bus.dbg_ra = 5'd7;
        tick();
        chk("dbg_r7", 64'(bus.dbg_rd), 64'h22);
`endif

        bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'hFFFF_FFFF;
        set_ra(5'd0);
        #1;
        chk("r0_same", 64'(rdp(0)), 64'd0);
        tick();
        quiet();
        #1;
        chk("r0_next", 64'(rdp(0)), 64'd0);

        bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'h99;
        tick();
        quiet();
        set_ra(5'd9);
        #1;
        chk("r9_old", 64'(rdp(2)), 64'h99);
        bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'hA5;
        #1;
        chk("byp_p0", 64'(rdp(0)), 64'hA5);
        chk("byp_p1", 64'(rdp(1)), 64'hA5);
        chk("byp_p2", 64'(rdp(2)), 64'hA5);
        tick();
        quiet();
        #1;
        chk("r9_new", 64'(rdp(1)), 64'hA5);

        bus.pend_set = 1'b1; bus.pend_sa = 5'd4;
        tick();
        quiet();
        chk("pend_set4", 64'(bus.pend), 64'h10);
        bus.pend_set = 1'b1; bus.pend_sa = 5'd0;
        tick();
        quiet();
        chk("pend_sa0", 64'(bus.pend), 64'h10);
        bus.we1 = 1'b1; bus.wa1 = 5'd4; bus.wd1 = 32'h44;
        tick();
        quiet();
        chk("pend_clr4", 64'(bus.pend), 64'd0);
        bus.pend_set = 1'b1; bus.pend_sa = 5'd4;
        bus.we0 = 1'b1; bus.wa0 = 5'd4; bus.wd0 = 32'h45;
        tick();
        quiet();
        chk("pend_setwin", 64'(bus.pend), 64'h10);

        bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h33;
        bus.pend_set = 1'b1; bus.pend_sa = 5'd3;
        tick();
        quiet();
        set_ra(5'd3);
        #1;
        chk("r3_load", 64'(rdp(0)), 64'h33);
        chk("pend_r3", 64'(bus.pend), 64'h18);
        bus.clr_req = 1'b1;
        tick();
        quiet();
        #1;
        chk("clr_ready", 64'(bus.ready), 64'd0);
        chk("clr_pend", 64'(bus.pend), 64'd0);
        for (int i = 0; i < 9; i++) tick();
        chk("clr_mid", 64'(bus.ready), 64'd0);
        bus.clr_req = 1'b1;
        tick();
        quiet();
        #1;
        for (int i = 0; i < 31; i++) begin
            chk("restart_ready", 64'(bus.ready), 64'd0);
            tick();
        end
        chk("restart_done", 64'(bus.ready), 64'd1);
        chk("r3_cleared", 64'(rdp(0)), 64'd0);
        chk("clr_pend_end", 64'(bus.pend), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
